// File: rtl/sram_dp_be.sv
// sram_dp_be: two-port byte-enable SRAM, write-first port A, read-only port B.
// Optional per-byte even parity storage when SRAM_DP_BE_PARITY_EN is defined.
module sram_dp_be #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 1024,
    parameter int OUT_REG = 0,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               BUSY,
    input  logic               EN_A,
    input  logic               WE_A,
    input  logic [WIDTH/8-1:0] WBE_A,
    input  logic [AW-1:0]      ADDR_A,
    input  logic [WIDTH-1:0]   DI_A,
    output logic [WIDTH-1:0]   DO_A,
    input  logic               EN_B,
    input  logic [AW-1:0]      ADDR_B,
    output logic [WIDTH-1:0]   DO_B,
    output logic               PERR_A,
    output logic               PERR_B
);
    localparam int NB = WIDTH / 8;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              rdy, rd_a, rd_b, a_ok, b_ok, wr_a, same;
    logic [NB-1:0]     be_a;
    logic [WIDTH-1:0]  old_a, merged, word_a, word_b;
    logic              perr_a_d, perr_b_d;
    logic [WIDTH-1:0]  d1_a, d1_b;
    logic              p1_a, p1_b;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:  if (cnt_q == LAST) state_d = READY;
            READY: state_d = READY;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                 cnt_q <= '0;
        else if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
    end

    assign BUSY = (state_q == INIT);
    assign rdy  = (state_q == READY);
    assign rd_a = rdy & EN_A;
    assign rd_b = rdy & EN_B;
    assign a_ok = {1'b0, ADDR_A} < DEPTH_W;
    assign b_ok = {1'b0, ADDR_B} < DEPTH_W;
    assign be_a = WE_A ? WBE_A : '0;
    assign old_a = a_ok ? mem[ADDR_A] : '0;

    always_comb begin
        merged = old_a;
        for (int i = 0; i < NB; i++)
            if (be_a[i]) merged[i*8 +: 8] = DI_A[i*8 +: 8];
    end

    // A write with no byte enabled is a plain read and leaves parity intact
    assign wr_a   = rd_a & a_ok & (|be_a);
    assign same   = wr_a & (ADDR_A == ADDR_B);
    assign word_a = a_ok ? merged : '0;
    assign word_b = !b_ok ? '0 : same ? merged : mem[ADDR_B];

    always_ff @(posedge CLK) begin
        if (state_q == INIT) mem[cnt_q]  <= '0;
        else if (wr_a)       mem[ADDR_A] <= merged;
    end

`ifdef SRAM_DP_BE_PARITY_EN
    logic [NB-1:0] par [DEPTH];

    function automatic logic [NB-1:0] par_of(input logic [WIDTH-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^w[i*8 +: 8];
        return p;
    endfunction

    always_ff @(posedge CLK) begin
        if (state_q == INIT) par[cnt_q]  <= '0;
        else if (wr_a)       par[ADDR_A] <= par_of(merged);
    end

    assign perr_a_d = a_ok & ~wr_a & (par_of(old_a) != par[ADDR_A]);
    assign perr_b_d = b_ok & ~same & (par_of(mem[ADDR_B]) != par[ADDR_B]);
`else
    assign perr_a_d = 1'b0;
    assign perr_b_d = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d1_a <= '0;
            d1_b <= '0;
            p1_a <= 1'b0;
            p1_b <= 1'b0;
        end else begin
            if (rd_a) begin
                d1_a <= word_a;
                p1_a <= perr_a_d;
            end
            if (rd_b) begin
                d1_b <= word_b;
                p1_b <= perr_b_d;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic             v_a, v_b, p2_a, p2_b;
        logic [WIDTH-1:0] d2_a, d2_b;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                v_a  <= 1'b0;
                v_b  <= 1'b0;
                d2_a <= '0;
                d2_b <= '0;
                p2_a <= 1'b0;
                p2_b <= 1'b0;
            end else begin
                v_a <= rd_a;
                v_b <= rd_b;
                if (v_a) begin
                    d2_a <= d1_a;
                    p2_a <= p1_a;
                end
                if (v_b) begin
                    d2_b <= d1_b;
                    p2_b <= p1_b;
                end
            end
        end

        assign DO_A   = d2_a;
        assign DO_B   = d2_b;
        assign PERR_A = p2_a;
        assign PERR_B = p2_b;
    end else begin : g_noreg
        assign DO_A   = d1_a;
        assign DO_B   = d1_b;
        assign PERR_A = p1_a;
        assign PERR_B = p1_b;
    end

endmodule

// File: tb/tb_sram_dp_be.sv
// tb_sram_dp_be: random and directed checks of sram_dp_be against a
// history-based read model; OUT_REG=0 and OUT_REG=1 instances run in lockstep.
module tb_sram_dp_be;
    localparam int DEPTH = 12;
    localparam int W     = 32;
    localparam int AW    = 4;
    localparam int HN    = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_a = 1'b0, we_a = 1'b0, en_b = 1'b0;
    logic [3:0]    wbe_a = '0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [W-1:0]  di_a = '0;

    logic          busy0, busy1, perr_a0, perr_b0, perr_a1, perr_b1;
    logic [W-1:0]  do_a0, do_b0, do_a1, do_b1;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] ref_mem [16];
    bit           bad     [16];
    int           init_left;
    int           cyc     = 0;
    int           rst_cyc = 0;
    bit           h_ea [HN];
    bit           h_eb [HN];
    bit           h_pa [HN];
    bit           h_pb [HN];
    logic [W-1:0] h_va [HN];
    logic [W-1:0] h_vb [HN];

    always #5 clk = ~clk;

    sram_dp_be #(.WIDTH(W), .DEPTH(DEPTH), .OUT_REG(0)) u0 (
        .CLK(clk), .RST(rst), .BUSY(busy0),
        .EN_A(en_a), .WE_A(we_a), .WBE_A(wbe_a), .ADDR_A(addr_a),
        .DI_A(di_a), .DO_A(do_a0),
        .EN_B(en_b), .ADDR_B(addr_b), .DO_B(do_b0),
        .PERR_A(perr_a0), .PERR_B(perr_b0)
    );

    sram_dp_be #(.WIDTH(W), .DEPTH(DEPTH), .OUT_REG(1)) u1 (
        .CLK(clk), .RST(rst), .BUSY(busy1),
        .EN_A(en_a), .WE_A(we_a), .WBE_A(wbe_a), .ADDR_A(addr_a),
        .DI_A(di_a), .DO_A(do_a1),
        .EN_B(en_b), .ADDR_B(addr_b), .DO_B(do_b1),
        .PERR_A(perr_a1), .PERR_B(perr_b1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp,
                     $time);
        end
    endtask

    // Latest enabled read issued at or before cycle 'from' since reset
    function automatic logic [32:0] expv(input bit pb, input int from);
        for (int c = from; c >= rst_cyc; c--) begin
            if (!pb && h_ea[c]) return {h_pa[c], h_va[c]};
            if (pb && h_eb[c])  return {h_pb[c], h_vb[c]};
        end
        return '0;
    endfunction

    task automatic step();
        bit           busy_m, ea, eb, ina, inb, wr;
        logic [3:0]   be;
        logic [W-1:0] old, mrg;
        logic [32:0]  e;
        busy_m = init_left > 0;
        ea  = en_a && !busy_m;
        eb  = en_b && !busy_m;
        ina = int'(addr_a) < DEPTH;
        inb = int'(addr_b) < DEPTH;
        be  = we_a ? wbe_a : 4'h0;
        old = ina ? ref_mem[addr_a] : '0;
        mrg = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) mrg[i*8 +: 8] = di_a[i*8 +: 8];
        wr = ea && ina && (be != 0);
        h_ea[cyc] = ea;
        h_va[cyc] = ina ? mrg : '0;
        h_pa[cyc] = ina && !wr && bad[addr_a];
        if (wr) begin
            ref_mem[addr_a] = mrg;
            bad[addr_a]     = 1'b0;
        end
        h_eb[cyc] = eb;
        h_vb[cyc] = inb ? ref_mem[addr_b] : '0;
        h_pb[cyc] = inb && bad[addr_b];
        @(posedge clk);
        #1;
        if (init_left > 0) init_left--;
        chk("busy0", 32'(busy0), 32'(init_left > 0));
        chk("busy1", 32'(busy1), 32'(init_left > 0));
        e = expv(0, cyc);
        chk("do_a0", do_a0, e[31:0]);
        chk("perr_a0", 32'(perr_a0), 32'(e[32]));
        e = expv(1, cyc);
        chk("do_b0", do_b0, e[31:0]);
        chk("perr_b0", 32'(perr_b0), 32'(e[32]));
        e = expv(0, cyc - 1);
        chk("do_a1", do_a1, e[31:0]);
        chk("perr_a1", 32'(perr_a1), 32'(e[32]));
        e = expv(1, cyc - 1);
        chk("do_b1", do_b1, e[31:0]);
        chk("perr_b1", 32'(perr_b1), 32'(e[32]));
        cyc++;
    endtask

    task automatic acc(input bit ea, input bit we, input logic [3:0] be,
                       input int aa, input logic [W-1:0] da,
                       input bit eb, input int ab);
        en_a   = ea;
        we_a   = we;
        wbe_a  = be;
        addr_a = AW'(aa);
        di_a   = da;
        en_b   = eb;
        addr_b = AW'(ab);
        step();
    endtask

    task automatic rand_acc();
        int aa;
        aa = $urandom_range(0, 15);
        acc(1'($urandom), 1'($urandom), 4'($urandom), aa, $urandom,
            1'($urandom), ($urandom_range(0, 3) == 0) ? aa
                                                     : $urandom_range(0, 15));
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        init_left = DEPTH;
        rst_cyc   = cyc;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0;
            bad[i]     = 1'b0;
        end
        chk("rst_busy", 32'(busy0 & busy1), 32'd1);
        chk("rst_do", do_a0 | do_b0 | do_a1 | do_b1, 32'd0);
        chk("rst_perr", 32'({perr_a0, perr_b0, perr_a1, perr_b1}), 32'd0);
        repeat (hold) @(posedge clk);
        #1;
        chk("rst_hold", 32'(busy0 & busy1), 32'd1);
        rst = 1'b0;
    endtask

    task automatic run_init(input string tag);
        int n = 0;
        while (busy0 && n < 100) begin
            rand_acc();
            n++;
        end
        chk(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        do_reset(3);
        run_init("init_len");

        for (int i = 0; i < DEPTH; i++) begin
            acc(1, 0, 4'h0, i, '0, 1, DEPTH - 1 - i);
            chk("clr_a", do_a0, 32'd0);
            chk("clr_b", do_b0, 32'd0);
        end

        acc(1, 1, 4'hF, 3, 32'hAABBCCDD, 0, 0);
        acc(1, 1, 4'h5, 3, 32'h11223344, 0, 0);
        acc(1, 0, 4'h0, 3, '0, 0, 0);
        chk("merge", do_a0, 32'hAA22CC44);
        acc(0, 0, 4'h0, 0, '0, 0, 0);
        chk("merge_r2", do_a1, 32'hAA22CC44);

        acc(1, 1, 4'h0, 3, 32'hFFFFFFFF, 0, 0);
        chk("wbe0_rd", do_a0, 32'hAA22CC44);

        acc(1, 1, 4'hF, 5, 32'h01234567, 0, 0);
        acc(1, 1, 4'hC, 5, 32'hDEADBEEF, 1, 5);
        chk("coll_b", do_b0, 32'hDEAD4567);
        chk("coll_a", do_a0, 32'hDEAD4567);

        acc(0, 0, 4'h0, 0, '0, 1, 3);
        chk("lat1_b", do_b0, 32'hAA22CC44);
        chk("lat2_early", do_b1, 32'hDEAD4567);
        acc(1, 1, 4'hF, 3, 32'hCAFEF00D, 0, 0);
        chk("lat2_b", do_b1, 32'hAA22CC44);
        chk("hold_b0", do_b0, 32'hAA22CC44);
        acc(0, 0, 4'h0, 0, '0, 0, 0);
        chk("hold_b1", do_b1, 32'hAA22CC44);

        acc(1, 1, 4'hF, 13, 32'hFFFFFFFF, 1, 14);
        chk("oor_a", do_a0, 32'd0);
        chk("oor_b", do_b0, 32'd0);

        repeat (400) rand_acc();

`ifdef SRAM_DP_BE_PARITY_EN
        acc(1, 1, 4'hF, 9, 32'h0F0F0F0F, 0, 0);
        acc(0, 0, 4'h0, 0, '0, 0, 0);
        u0.mem[9]  = u0.mem[9] ^ 32'h1;
        u1.mem[9]  = u1.mem[9] ^ 32'h1;
        ref_mem[9] = ref_mem[9] ^ 32'h1;
        bad[9]     = 1'b1;
        acc(0, 0, 4'h0, 0, '0, 1, 9);
        chk("perr_hit", 32'(perr_b0), 32'd1);
        chk("perr_do", do_b0, 32'h0F0F0F0E);
        acc(0, 0, 4'h0, 0, '0, 1, 2);
        chk("perr_clr", 32'(perr_b0), 32'd0);
        chk("perr_hit2", 32'(perr_b1), 32'd1);
        acc(0, 0, 4'h0, 0, '0, 0, 0);
        chk("perr_clr2", 32'(perr_b1), 32'd0);
        repeat (100) rand_acc();
`endif

        acc(1, 1, 4'hF, 7, 32'h12345678, 1, 3);
        do_reset(1);
        repeat (7) rand_acc();
        do_reset(2);
        run_init("reinit_len");
        acc(1, 0, 4'h0, 7, '0, 1, 3);
        chk("reclr_a", do_a0, 32'd0);
        chk("reclr_b", do_b0, 32'd0);

        repeat (200) rand_acc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
